// File: rtl/sng_corr_pair.sv
// Correlated stochastic operand pair for CORDIV: both operand streams compare against one shared LFSR,
// and a second, independently seeded LFSR supplies the select stream.
module sng_corr_pair #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] SEED     = 8'hA5,
   parameter logic [WIDTH-1:0] SEL_SEED = 8'h3C,
   parameter logic [WIDTH-1:0] TAPS     = 8'hB8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend_val,
   input  logic [WIDTH-1:0] divisor_val,
   input  logic             en,
   output logic             busy,
   output logic             bit_valid,
   output logic             dividend_bit,
   output logic             divisor_bit,
   output logic             sel_bit,
   output logic             done
);

   // Index of the last element in a stream of 2^WIDTH-1 elements.
   localparam logic [WIDTH-1:0] LAST = WIDTH'((2 ** WIDTH) - 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] dividend_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic             load;
   logic             advance;

   // Slot 0 drives the operand comparisons, slot 1 the select bit.
   logic [1:0][WIDTH-1:0] lfsr_cur;

   assign load    = (state_reg == ST_IDLE) && start;
   assign advance = (state_reg == ST_RUN) && en;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lfsr
         localparam logic [WIDTH-1:0] RELOAD = (gi == 0) ? SEED : SEL_SEED;
         logic [WIDTH-1:0] lfsr_reg;
         logic [WIDTH-1:0] lfsr_next;

         always_comb begin
            lfsr_next = lfsr_reg;
            if (load) begin
               lfsr_next = RELOAD;
            end else if (advance) begin
               lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lfsr_reg <= RELOAD;
            end else begin
               lfsr_reg <= lfsr_next;
            end
         end

         assign lfsr_cur[gi] = lfsr_reg;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end
         ST_RUN: begin
            if (en) begin
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (load) begin
            dividend_reg <= dividend_val;
            divisor_reg  <= divisor_val;
         end
      end
   end

   // Shared LFSR across both comparisons gives maximal positive correlation.
   assign busy         = (state_reg == ST_RUN);
   assign bit_valid    = advance;
   assign done         = (state_reg == ST_DONE);
   assign dividend_bit = bit_valid && (lfsr_cur[0] <= dividend_reg);
   assign divisor_bit  = bit_valid && (lfsr_cur[0] <= divisor_reg);
   assign sel_bit      = bit_valid && lfsr_cur[1][0];

endmodule

// File: tb/tb_sng_corr_pair.sv
// Directed bench for sng_corr_pair: table-driven full streams against a reference LFSR,
// plus hand-written reset-mid-run and held-start sequences.
module tb_sng_corr_pair;

   localparam int         N        = 255;
   localparam logic [7:0] SEED     = 8'hA5;
   localparam logic [7:0] SEL_SEED = 8'h3C;
   localparam logic [7:0] TAPS     = 8'hB8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       en = 1'b0;
   logic [7:0] dividend_val = 8'd0;
   logic [7:0] divisor_val = 8'd0;
   logic       busy;
   logic       bit_valid;
   logic       dividend_bit;
   logic       divisor_bit;
   logic       sel_bit;
   logic       done;

   int total = 0;
   int bad = 0;

   typedef struct {
      string      name;
      logic [7:0] d;
      logic [7:0] v;
      bit         stall;
      int         exp_d;
      int         exp_v;
      int         exp_viol;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   sng_corr_pair dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .dividend_val (dividend_val),
      .divisor_val  (divisor_val),
      .en           (en),
      .busy         (busy),
      .bit_valid    (bit_valid),
      .dividend_bit (dividend_bit),
      .divisor_bit  (divisor_bit),
      .sel_bit      (sel_bit),
      .done         (done)
   );

   function automatic logic [7:0] step(input logic [7:0] r);
      return r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Called #1 after a posedge while IDLE; returns #1 after the accept edge.
   task automatic kick(input logic [7:0] d, input logic [7:0] v);
      start        = 1'b1;
      dividend_val = d;
      divisor_val  = v;
      en           = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called #1 after the accept edge; consumes the stream, the DONE cycle and the following IDLE cycle.
   task automatic stream(input string name, input logic [7:0] d, input logic [7:0] v, input bit stall,
                         input int exp_d, input int exp_v, input int exp_viol,
                         input bit keep_start, input logic [7:0] next_d, input logic [7:0] next_v);
      logic [7:0] ml;
      logic [7:0] ms;
      int nvalid, ones_d, ones_v, viol, seq_err, busy_err, cyc;
      bit e;
      ml = SEED;
      ms = SEL_SEED;
      nvalid = 0; ones_d = 0; ones_v = 0; viol = 0; seq_err = 0; busy_err = 0; cyc = 0;
      if (keep_start) begin
         start        = 1'b1;
         dividend_val = 8'd200;
         divisor_val  = 8'd210;
      end else begin
         start = 1'b0;
      end
      while (nvalid < N && cyc < 2000) begin
         e  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         en = e;
         @(negedge clk);
         if (busy !== 1'b1) busy_err++;
         if (bit_valid !== e) seq_err++;
         if (e) begin
            if (dividend_bit !== (ml <= d)) seq_err++;
            if (divisor_bit !== (ml <= v)) seq_err++;
            if (sel_bit !== ms[0]) seq_err++;
            if (dividend_bit === 1'b1) ones_d++;
            if (divisor_bit === 1'b1) ones_v++;
            if (dividend_bit === 1'b1 && divisor_bit !== 1'b1) viol++;
            ml = step(ml);
            ms = step(ms);
            nvalid++;
         end else if (dividend_bit !== 1'b0 || divisor_bit !== 1'b0 || sel_bit !== 1'b0) begin
            seq_err++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check({name, "_valid_count"}, nvalid, N);
      check({name, "_seq_err"}, seq_err, 0);
      check({name, "_busy_err"}, busy_err, 0);
      check({name, "_ones_dividend"}, ones_d, exp_d);
      check({name, "_ones_divisor"}, ones_v, exp_v);
      check({name, "_corr_viol"}, viol, exp_viol);
      en = 1'b1;
      if (keep_start) begin
         dividend_val = next_d;
         divisor_val  = next_v;
      end
      @(negedge clk);
      check({name, "_done_pulse"}, int'(done), 1);
      check({name, "_done_busy_valid"}, int'({busy, bit_valid}), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check({name, "_idle_done_busy"}, int'({done, busy}), 0);
      @(posedge clk);
      #1;
      $display("stream %s d=%0d v=%0d stall=%0d valid=%0d ones_d=%0d ones_v=%0d viol=%0d seq_err=%0d",
               name, d, v, stall, nvalid, ones_d, ones_v, viol, seq_err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{"t2_64_200",   8'd64,  8'd200, 1'b0, 64,  200, 0};
      vecs[1] = '{"t3_0_255",    8'd0,   8'd255, 1'b0, 0,   255, 0};
      vecs[2] = '{"t4_100_150",  8'd100, 8'd150, 1'b0, 100, 150, 0};
      vecs[3] = '{"t5_stall_37", 8'd37,  8'd90,  1'b1, 37,  90,  0};
      vecs[4] = '{"rev_255_0",   8'd255, 8'd0,   1'b0, 255, 0,   255};
      vecs[5] = '{"stall_1_254", 8'd1,   8'd254, 1'b1, 1,   254, 0};

      // Reset state, with en already high so bit_valid must still stay low.
      en = 1'b1;
      #2;
      check("reset_outputs", int'({busy, bit_valid, done, dividend_bit, divisor_bit, sel_bit}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("idle_outputs", int'({busy, bit_valid, done, dividend_bit, divisor_bit, sel_bit}), 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         kick(vecs[i].d, vecs[i].v);
         stream(vecs[i].name, vecs[i].d, vecs[i].v, vecs[i].stall,
                vecs[i].exp_d, vecs[i].exp_v, vecs[i].exp_viol, 1'b0, 8'd0, 8'd0);
      end

      // Reset mid-RUN: asynchronous clear, no done pulse, next stream restarts from the seeds.
      kick(8'd255, 8'd255);
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
      end
      #3;
      check("t1_busy_before_reset", int'({busy, bit_valid}), 3);
      rst_n = 1'b0;
      #1;
      check("t1_async_clear", int'({busy, bit_valid, done, dividend_bit, divisor_bit, sel_bit}), 0);
      @(negedge clk);
      check("t1_no_done_in_reset", int'(done), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t1_after_release", int'({busy, done}), 0);
      @(posedge clk);
      #1;
      kick(8'd64, 8'd128);
      stream("t1_restart", 8'd64, 8'd128, 1'b0, 64, 128, 0, 1'b0, 8'd0, 8'd0);

      // Start held through RUN and DONE; second stream takes the inputs present at its accept edge.
      start        = 1'b1;
      dividend_val = 8'd10;
      divisor_val  = 8'd20;
      en           = 1'b1;
      @(posedge clk);
      #1;
      stream("t6_first", 8'd10, 8'd20, 1'b0, 10, 20, 0, 1'b1, 8'd30, 8'd40);
      stream("t6_second", 8'd30, 8'd40, 1'b0, 30, 40, 0, 1'b0, 8'd0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
